omem: RTL and testbench

Output memory for the spiking-network accelerator, attached to the NoC at node address 12. It stores membrane potentials and per-timestep spike bits written by the processing elements (PEs) over the router. It answers PE requests for the previous-timestep potential. After the final timestep it streams every spike, timestep by timestep, to the host-side output channels.

---
 rtl/omem_if.sv | 36 +++
 rtl/omem.sv | 173 +++++++++++++++++
 tb/tb_omem.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/omem_if.sv
// omem_if: valid/ready channels between the output memory, the router and the host outputs
interface omem_if #(parameter int PW = 33);
    logic          router_in_valid, router_in_ready;
    logic [PW-1:0] router_in_data;
    logic          router_out_valid, router_out_ready;
    logic [PW-1:0] router_out_data;
    logic          start_r_valid, start_r_ready, start_r_data;
    logic          ts_r_valid, ts_r_ready;
    logic [3:0]    ts_r_data;
    logic          layer_r_valid, layer_r_ready;
    logic [3:0]    layer_r_data;
    logic          out_spike_addr_valid, out_spike_addr_ready;
    logic [8:0]    out_spike_addr_data;
    logic          out_spike_data_valid, out_spike_data_ready, out_spike_data_data;
    logic          done_r_valid, done_r_ready, done_r_data;
    modport slave (
        input  router_in_valid, router_in_data, output router_in_ready,
        output router_out_valid, router_out_data, input router_out_ready,
        output start_r_valid, start_r_data, input start_r_ready,
        output ts_r_valid, ts_r_data, input ts_r_ready,
        output layer_r_valid, layer_r_data, input layer_r_ready,
        output out_spike_addr_valid, out_spike_addr_data, input out_spike_addr_ready,
        output out_spike_data_valid, out_spike_data_data, input out_spike_data_ready,
        output done_r_valid, done_r_data, input done_r_ready
    );
    modport master (
        output router_in_valid, router_in_data, input router_in_ready,
        input  router_out_valid, router_out_data, output router_out_ready,
        input  start_r_valid, start_r_data, output start_r_ready,
        input  ts_r_valid, ts_r_data, output ts_r_ready,
        input  layer_r_valid, layer_r_data, output layer_r_ready,
        input  out_spike_addr_valid, out_spike_addr_data, output out_spike_addr_ready,
        input  out_spike_data_valid, out_spike_data_data, output out_spike_data_ready,
        input  done_r_valid, done_r_data, output done_r_ready
    );
endinterface

// File: rtl/omem.sv
// omem: output memory storing PE potentials/spikes, answering previous-timestep reads and dumping spikes to the host
module omem #(
    parameter int NUM_NEURONS = 441,
    parameter int NUM_TS      = 2,
    parameter int LAYER_ID    = 1,
    parameter int PW          = 33
) (
    input logic   clk,
    input logic   rst,
    omem_if.slave io_bus
);
    localparam int AW = $clog2(NUM_NEURONS);
    localparam int TW = (NUM_TS > 1) ? $clog2(NUM_TS) : 1;
    localparam logic [2:0] S_COLLECT = 3'd0, S_REPLY = 3'd1, S_START = 3'd2, S_TS = 3'd3,
                           S_LAYER = 3'd4, S_SPIKE = 3'd5, S_DONE = 3'd6;
    localparam logic [AW-1:0] LAST = AW'(NUM_NEURONS - 1);
    localparam logic [3:0] TS_LAST = 4'(NUM_TS);
    logic [2:0] r_state;
    logic [AW-1:0] r_wr_idx, r_rd_idx, r_n;
    logic [3:0] r_ts, r_d;
    logic [23:0] r_pot [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] r_spk [NUM_TS];
    logic r_addr_done, r_bit_done;
    logic r_out_v, r_start_v, r_start_d, r_ts_v, r_layer_v, r_addr_v, r_bit_v, r_bit_d, r_done_v, r_done_d;
    logic [PW-1:0] r_out_d;
    logic [3:0] r_ts_d, r_layer_d;
    logic [AW-1:0] r_addr_d;
    logic w_in_hs, w_wr, w_rd, w_out_hs, w_start_hs, w_ts_hs, w_layer_hs, w_done_hs;
    logic w_addr_hs, w_bit_hs, w_addr_fin, w_bit_fin, w_unused;
    logic [TW-1:0] w_wts, w_dts;
    logic [AW-1:0] w_n_nxt;
    logic [23:0] w_prev;
    logic [2:0] w_pe;
    assign w_in_hs    = io_bus.router_in_valid && r_state == S_COLLECT;
    assign w_wr       = w_in_hs && !io_bus.router_in_data[25];
    assign w_rd       = w_in_hs && io_bus.router_in_data[25];
    assign w_out_hs   = r_out_v && io_bus.router_out_ready;
    assign w_start_hs = r_start_v && io_bus.start_r_ready;
    assign w_ts_hs    = r_ts_v && io_bus.ts_r_ready;
    assign w_layer_hs = r_layer_v && io_bus.layer_r_ready;
    assign w_addr_hs  = r_addr_v && io_bus.out_spike_addr_ready;
    assign w_bit_hs   = r_bit_v && io_bus.out_spike_data_ready;
    assign w_done_hs  = r_done_v && io_bus.done_r_ready;
    assign w_addr_fin = r_addr_done || w_addr_hs;
    assign w_bit_fin  = r_bit_done || w_bit_hs;
    assign w_wts      = TW'(r_ts - 4'd1);
    assign w_dts      = TW'(r_d - 4'd1);
    assign w_n_nxt    = r_n + AW'(1);
    assign w_prev     = (r_ts > 4'd1) ? r_pot[r_rd_idx] : 24'd0;
    assign w_pe       = io_bus.router_in_data[28:26];
    assign w_unused   = ^io_bus.router_in_data[PW-1:29];
    assign io_bus.router_in_ready      = r_state == S_COLLECT;
    assign io_bus.router_out_valid     = r_out_v;
    assign io_bus.router_out_data      = r_out_d;
    assign io_bus.start_r_valid        = r_start_v;
    assign io_bus.start_r_data         = r_start_d;
    assign io_bus.ts_r_valid           = r_ts_v;
    assign io_bus.ts_r_data            = r_ts_d;
    assign io_bus.layer_r_valid        = r_layer_v;
    assign io_bus.layer_r_data         = r_layer_d;
    assign io_bus.out_spike_addr_valid = r_addr_v;
    assign io_bus.out_spike_addr_data  = 9'(r_addr_d);
    assign io_bus.out_spike_data_valid = r_bit_v;
    assign io_bus.out_spike_data_data  = r_bit_d;
    assign io_bus.done_r_valid         = r_done_v;
    assign io_bus.done_r_data          = r_done_d;
    // RAMs are deliberately outside the reset domain so contents survive across runs
    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            r_pot[r_wr_idx] <= io_bus.router_in_data[24:1];
            r_spk[w_wts][r_wr_idx] <= io_bus.router_in_data[0];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_COLLECT;
            r_ts <= 4'd1;
            r_d <= 4'd1;
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_n <= '0;
            r_addr_done <= 1'b0;
            r_bit_done <= 1'b0;
            {r_out_v, r_start_v, r_ts_v, r_layer_v, r_addr_v, r_bit_v, r_done_v} <= '0;
            {r_out_d, r_start_d, r_ts_d, r_layer_d, r_addr_d, r_bit_d, r_done_d} <= '0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_wr) begin
                        if (r_wr_idx == LAST) begin
                            r_wr_idx <= '0;
                            r_rd_idx <= '0;
                            if (r_ts == TS_LAST) begin
                                r_state <= S_START;
                                r_start_v <= 1'b1;
                                r_start_d <= 1'b1;
                            end else r_ts <= r_ts + 4'd1;
                        end else r_wr_idx <= r_wr_idx + AW'(1);
                    end else if (w_rd) begin
                        r_state <= S_REPLY;
                        r_out_v <= 1'b1;
                        r_out_d <= PW'({1'b0, w_pe, w_pe, 1'b1, w_prev, 1'b0});
                    end
                end
                S_REPLY: if (w_out_hs) begin
                    r_out_v <= 1'b0;
                    r_rd_idx <= (r_rd_idx == LAST) ? '0 : r_rd_idx + AW'(1);
                    r_state <= S_COLLECT;
                end
                S_START: if (w_start_hs) begin
                    r_start_v <= 1'b0;
                    r_d <= 4'd1;
                    r_ts_v <= 1'b1;
                    r_ts_d <= 4'd1;
                    r_state <= S_TS;
                end
                S_TS: if (w_ts_hs) begin
                    r_ts_v <= 1'b0;
                    r_layer_v <= 1'b1;
                    r_layer_d <= 4'(LAYER_ID);
                    r_n <= '0;
                    r_state <= S_LAYER;
                end
                S_LAYER: if (w_layer_hs) begin
                    r_layer_v <= 1'b0;
                    r_addr_v <= 1'b1;
                    r_addr_d <= r_n;
                    r_bit_v <= 1'b1;
                    r_bit_d <= r_spk[w_dts][r_n];
                    r_state <= S_SPIKE;
                end
                S_SPIKE: begin
                    if (w_addr_hs) r_addr_v <= 1'b0;
                    if (w_bit_hs) r_bit_v <= 1'b0;
                    // address and spike bit complete independently; advance only once both are taken
                    if (w_addr_fin && w_bit_fin) begin
                        r_addr_done <= 1'b0;
                        r_bit_done <= 1'b0;
                        if (r_n == LAST) begin
                            if (r_d == TS_LAST) begin
                                r_done_v <= 1'b1;
                                r_done_d <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_d <= r_d + 4'd1;
                                r_ts_v <= 1'b1;
                                r_ts_d <= r_d + 4'd1;
                                r_state <= S_TS;
                            end
                        end else begin
                            r_n <= w_n_nxt;
                            r_addr_v <= 1'b1;
                            r_addr_d <= w_n_nxt;
                            r_bit_v <= 1'b1;
                            r_bit_d <= r_spk[w_dts][w_n_nxt];
                        end
                    end else begin
                        r_addr_done <= w_addr_fin;
                        r_bit_done <= w_bit_fin;
                    end
                end
                S_DONE: if (w_done_hs) begin
                    r_done_v <= 1'b0;
                    r_ts <= 4'd1;
                    r_wr_idx <= '0;
                    r_rd_idx <= '0;
                    r_state <= S_COLLECT;
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_omem.sv
// tb_omem: scoreboard bench for omem covering collect, replies, dump order and back-pressure over two runs
module tb_omem;
    localparam int N = 441;
    logic clk = 1'b0;
    logic rst = 1'b1;
    omem_if #(.PW(33)) b ();
    omem dut (.clk(clk), .rst(rst), .io_bus(b));
    always #5 clk = ~clk;
    int n_checks = 0;
    int n_pass = 0;
    int done_cnt = 0;
    logic [32:0] rep_q [$];
    logic [11:0] ctl_q [$];
    logic        spk_q [$];
    logic [11:0] m_ev [5];
    logic [4:0]  m_hs;
    logic [11:0] m_e;
    logic [32:0] m_r;
    logic        m_s;
    always @(negedge clk) begin
        if (!rst) begin
            if (b.router_out_valid && b.router_out_ready) begin
                n_checks++;
                if (rep_q.size() == 0) $display("FAIL reply_unexpected got=%h", b.router_out_data);
                else begin
                    m_r = rep_q.pop_front();
                    if (b.router_out_data !== m_r) $display("FAIL reply got=%h exp=%h", b.router_out_data, m_r);
                    else n_pass++;
                end
            end
            m_hs = {b.done_r_valid && b.done_r_ready, b.out_spike_addr_valid && b.out_spike_addr_ready,
                    b.layer_r_valid && b.layer_r_ready, b.ts_r_valid && b.ts_r_ready, b.start_r_valid && b.start_r_ready};
            m_ev[0] = {3'd1, 8'd0, b.start_r_data};
            m_ev[1] = {3'd2, 5'd0, b.ts_r_data};
            m_ev[2] = {3'd3, 5'd0, b.layer_r_data};
            m_ev[3] = {3'd4, b.out_spike_addr_data};
            m_ev[4] = {3'd6, 8'd0, b.done_r_data};
            for (int c = 0; c < 5; c++) begin
                if (m_hs[c]) begin
                    n_checks++;
                    if (ctl_q.size() == 0) $display("FAIL ctl_unexpected got=%h", m_ev[c]);
                    else begin
                        m_e = ctl_q.pop_front();
                        if (m_ev[c] !== m_e) $display("FAIL ctl_order got=%h exp=%h", m_ev[c], m_e);
                        else n_pass++;
                    end
                end
            end
            if (m_hs[4]) done_cnt++;
            if (b.out_spike_data_valid && b.out_spike_data_ready) begin
                n_checks++;
                if (spk_q.size() == 0) $display("FAIL spike_unexpected got=%b", b.out_spike_data_data);
                else begin
                    m_s = spk_q.pop_front();
                    if (b.out_spike_data_data !== m_s) $display("FAIL spike_bit got=%b exp=%b", b.out_spike_data_data, m_s);
                    else n_pass++;
                end
            end
        end
    end
    function automatic logic [32:0] rd_pkt(input logic [2:0] pe);
        return {4'd12, pe, 1'b1, 25'd0};
    endfunction
    function automatic logic [32:0] wr_pkt(input logic [23:0] pot, input logic s);
        return {4'd12, 3'd1, 1'b0, pot, s};
    endfunction
    function automatic logic [32:0] exp_reply(input logic [2:0] pe, input logic [23:0] pot);
        return {1'b0, pe, pe, 1'b1, pot, 1'b0};
    endfunction
    task automatic set_dump_ready(input logic v, input logic bp);
        b.start_r_ready        = bp ? 1'($urandom_range(0, 1)) : v;
        b.ts_r_ready           = bp ? 1'($urandom_range(0, 1)) : v;
        b.layer_r_ready        = bp ? 1'($urandom_range(0, 1)) : v;
        b.out_spike_addr_ready = bp ? 1'($urandom_range(0, 1)) : v;
        b.out_spike_data_ready = bp ? 1'($urandom_range(0, 1)) : v;
        b.done_r_ready         = bp ? 1'($urandom_range(0, 1)) : v;
    endtask
    task automatic send(input logic [32:0] p);
        int k = 0;
        b.router_in_valid = 1'b1;
        b.router_in_data = p;
        @(negedge clk);
        while (!b.router_in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!b.router_in_ready) begin
            n_checks++;
            $display("FAIL send_timeout ready=%b exp=1", b.router_in_ready);
        end
        @(posedge clk);
        #1;
        b.router_in_valid = 1'b0;
        b.router_in_data = '0;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        b.router_in_valid = 1'b0;
        b.router_in_data = '0;
        b.router_out_ready = 1'b0;
        set_dump_ready(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({b.router_out_valid, b.start_r_valid, b.ts_r_valid, b.layer_r_valid, b.out_spike_addr_valid,
                 b.out_spike_data_valid, b.done_r_valid, b.router_in_ready} !== 8'b0000_0001)
                $display("FAIL reset_valids got=%b exp=00000001", {b.router_out_valid, b.start_r_valid, b.ts_r_valid,
                         b.layer_r_valid, b.out_spike_addr_valid, b.out_spike_data_valid, b.done_r_valid, b.router_in_ready});
            else n_pass++;
        end
        n_checks++;
        if ({b.router_out_data, b.start_r_data, b.ts_r_data, b.layer_r_data, b.out_spike_addr_data,
             b.out_spike_data_data, b.done_r_data} !== 53'd0)
            $display("FAIL reset_data got=%h exp=0", {b.router_out_data, b.start_r_data, b.ts_r_data, b.layer_r_data,
                     b.out_spike_addr_data, b.out_spike_data_data, b.done_r_data});
        else n_pass++;
        @(posedge clk);
        #1;
    endtask
    task automatic test_collect();
        b.router_out_ready = 1'b1;
        rep_q.push_back(exp_reply(3'd3, 24'd0));
        send(rd_pkt(3'd3));
        for (int i = 0; i < N; i++) send(wr_pkt(24'(i), 1'(i % 2)));
        @(negedge clk);
        n_checks++;
        if (b.start_r_valid !== 1'b0 || b.router_in_ready !== 1'b1 || rep_q.size() != 0)
            $display("FAIL ts1_end start=%b ready=%b pending=%0d exp start=0 ready=1 pending=0",
                     b.start_r_valid, b.router_in_ready, rep_q.size());
        else n_pass++;
        @(posedge clk);
        #1;
    endtask
    task automatic test_interleave();
        for (int i = 0; i < N; i++) begin
            rep_q.push_back(exp_reply(3'(i % 5), 24'(i)));
            if (i == 0) b.router_out_ready = 1'b0;
            send(rd_pkt(3'(i % 5)));
            if (i == 0) begin
                repeat (5) begin
                    @(negedge clk);
                    n_checks++;
                    if (b.router_in_ready !== 1'b0 || b.router_out_valid !== 1'b1)
                        $display("FAIL reply_stall ready=%b valid=%b exp ready=0 valid=1", b.router_in_ready, b.router_out_valid);
                    else n_pass++;
                end
                @(posedge clk);
                #1 b.router_out_ready = 1'b1;
            end
            send(wr_pkt(24'hA00000 | 24'(i), 1'(i % 3 == 0)));
        end
        @(negedge clk);
        n_checks++;
        if (rep_q.size() != 0 || b.router_in_ready !== 1'b0)
            $display("FAIL ts2_end pending=%0d ready=%b exp pending=0 ready=0", rep_q.size(), b.router_in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask
    task automatic test_dump(input logic bp);
        int k = 0;
        int d0 = done_cnt;
        ctl_q.push_back({3'd1, 9'd1});
        for (int d = 1; d <= 2; d++) begin
            ctl_q.push_back({3'd2, 9'(d)});
            ctl_q.push_back({3'd3, 9'd1});
            for (int n = 0; n < N; n++) begin
                ctl_q.push_back({3'd4, 9'(n)});
                spk_q.push_back(d == 1 ? 1'(n % 2) : 1'(n % 3 == 0));
            end
        end
        ctl_q.push_back({3'd6, 9'd1});
        while (done_cnt == d0 && k < 20000) begin
            @(posedge clk);
            #1 set_dump_ready(1'b1, bp);
            k++;
        end
        n_checks++;
        if (done_cnt == d0) $display("FAIL dump_timeout done_seen=0 exp=1");
        else n_pass++;
        set_dump_ready(1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (ctl_q.size() != 0 || spk_q.size() != 0 || b.router_in_ready !== 1'b1 || b.done_r_valid !== 1'b0)
            $display("FAIL dump_end ctl_left=%0d spk_left=%0d ready=%b done_v=%b exp 0 0 1 0",
                     ctl_q.size(), spk_q.size(), b.router_in_ready, b.done_r_valid);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask
    initial begin
        test_reset();
        test_collect();
        test_interleave();
        test_dump(1'b0);
        test_collect();
        test_interleave();
        test_dump(1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
    initial begin
        #5_000_000;
        $display("FAIL watchdog passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
